fir_dec_downsampler: RTL and testbench
======================================

// Module: fir_dec_downsampler
// PURPOSE
//  Downstream stage of the decimate-by-3 FIR (20-bit transposed-form MAC output, one sample per enabled clk).
//  Discards filter warm-up, keeps one sample in DEC, rounds/saturates it to WOUT bits and buffers it in a FIFO.
//  Output is a valid/ready stream to the polyphase combiner / capture logic; sticky flags report saturation and drops.
// PARAMETERS
//  WIN        20  input width (FIR output width)
//  WOUT       12  output width after scaling
//  SHIFT       8  LSBs removed by rounding (SHIFT>=1)
//  DEC         3  decimation factor (>=2)
//  OFFSET      0  kept phase, 0..DEC-1
//  WARMUP     21  accepted input samples discarded after reset/clear (= FIR tap count)
//  DEPTH       4  output FIFO depth (power of 2)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  reset      in   1     asynchronous, active-low
//  sync_clr   in   1     synchronous clear of phase, warm-up, FIFO, flags
//  in_valid   in   1     in_data qualifier (FIR sample strobe)
//  in_data    in   WIN   signed two's-complement FIR output
//  out_valid  out  1     FIFO not empty
//  out_ready  in   1     consumer accepts out_data when out_valid&out_ready
//  out_data   out  WOUT  signed decimated sample (FIFO head)
//  phase      out  clog2(DEC)  current decimation phase
//  sat_flag   out  1     sticky: a kept sample was saturated
//  drop_flag  out  1     sticky: a kept sample was lost (FIFO full)
// BEHAVIOUR
//  Reset reset, asynchronous, active-low; clock clk. Reset clears all outputs to 0: out_valid, out_data, phase, flags.
//  sync_clr has priority over all other activity in its cycle; result equals reset state; input in that cycle ignored.
//  Warm-up: counter wu from 0; while wu<WARMUP each in_valid increments wu, phase held at 0, nothing kept.
//  After warm-up: each in_valid advances phase 0..DEC-1, wraps DEC-1 -> 0; sample kept when phase==OFFSET (pre-increment).
//  in_valid low: phase, wu, pipeline unchanged.
//  Round/sat stage (1 reg): r = (in_data + 2^(SHIFT-1)) >>> SHIFT, full precision WIN+1 bits, round half up;
//    r > 2^(WOUT-1)-1 -> clamp max, r < -2^(WOUT-1) -> clamp min, sets sat_flag. Stage valid = kept.
//  FIFO push when stage valid; push accepted if count<DEPTH or a pop occurs same cycle; else sample discarded, drop_flag set.
//  Pop when out_valid&out_ready; pop on empty impossible (out_valid low). Push+pop same cycle: count unchanged, order kept.
//  Latency: kept sample sampled at edge E -> stage reg at E -> FIFO write at E+1 -> out_valid/out_data valid after E+1 (2 clk).
//  out_data stable while out_valid&~out_ready. Flags cleared only by reset or sync_clr.
//  Reset mid-stream: FIFO contents lost, warm-up restarts; no partial output emitted.
// STRUCTURE
//  Package fir_dec_pkg: WIN/WOUT/SHIFT defaults, DEC, WARMUP, clog2 helper, round/saturate function.
//  Sub-module fir_dec_fifo: synchronous DEPTH x WOUT FIFO, push/pop/full/empty/count, async active-low reset, sync clear.
//  Top holds warm-up counter, phase counter, round/sat register, flag logic.
// TESTING
//  Reset then 21 in_valid pulses of 1000 -> no out_valid; phase stays 0.
//  After warm-up, ramp 0,256,512,... with out_ready=1 -> outputs 0,3,6,... (every 3rd input >>>8), each 2 clk after input.
//  Inputs 128 and -129 kept -> out_data 1 and -1 (round half up); 0x7FFFF -> 2047, sat_flag=1; -524288 -> -2048.
//  out_ready=0, 6 kept samples -> first 4 buffered, drop_flag=1; release ready -> exactly 4 outputs in order.
//  FIFO full, push+pop same cycle -> no drop, count stays 4, order preserved.
//  Assert reset (or sync_clr) mid-stream with FIFO holding 2 -> out_valid=0 next cycle, flags 0, 21-sample warm-up repeats.

Source files
------------

// File: rtl/fir_dec_pkg.sv
// Shared constants, payload type and round/saturate helper for the FIR decimator back end.
package fir_dec_pkg;

    localparam int unsigned WIN    = 20;
    localparam int unsigned WOUT   = 12;
    localparam int unsigned SHIFT  = 8;
    localparam int unsigned DEC    = 3;
    localparam int unsigned OFFSET = 0;
    localparam int unsigned WARMUP = 21;
    localparam int unsigned DEPTH  = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    localparam int unsigned PW   = (clog2(DEC) > 0) ? clog2(DEC) : 1;
    localparam int unsigned WUW  = clog2(WARMUP + 1);
    localparam int unsigned WSUM = WIN + 1;

    typedef struct packed {
        logic                   sat;
        logic signed [WOUT-1:0] data;
    } rs_t;

    // Round half up at bit SHIFT, then clamp to the signed WOUT range.
    function automatic rs_t round_sat(input logic signed [WIN-1:0] x);
        logic signed [WSUM-1:0] ext;
        logic signed [WSUM-1:0] half;
        logic signed [WSUM-1:0] sum;
        logic signed [WSUM-1:0] r;
        logic signed [WSUM-1:0] maxv;
        logic signed [WSUM-1:0] minv;
        rs_t                    res;
        ext            = {x[WIN-1], x};
        half           = '0;
        half[SHIFT-1]  = 1'b1;
        sum            = ext + half;
        r              = sum >>> SHIFT;
        maxv           = '0;
        maxv[WOUT-2:0] = '1;
        minv           = ~maxv;
        res.sat        = 1'b0;
        res.data       = WOUT'(r);
        if (r > maxv) begin
            res.sat  = 1'b1;
            res.data = WOUT'(maxv);
        end else if (r < minv) begin
            res.sat  = 1'b1;
            res.data = WOUT'(minv);
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_dec_fifo.sv
// Synchronous D x W output FIFO; push while full is accepted only when a pop frees a slot.
module fir_dec_fifo
    import fir_dec_pkg::*;
#(
    parameter int unsigned W = WOUT,
    parameter int unsigned D = DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = clog2(D);
    localparam int unsigned CW = clog2(D + 1);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push_c;
    logic          do_pop_c;

    assign full      = (count == CW'(D));
    assign empty     = (count == '0);
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);
    assign rdata     = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < D; i++) mem[AW'(i)] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < D; i++) mem[AW'(i)] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_dec_downsampler.sv
// Warm-up discard, decimate-by-DEC phase select, round/saturate stage and buffered
// valid/ready output for the FIR decimator.
module fir_dec_downsampler
    import fir_dec_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            sync_clr,
    input  logic            in_valid,
    input  logic [WIN-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WOUT-1:0] out_data,
    output logic [PW-1:0]   phase,
    output logic            sat_flag,
    output logic            drop_flag
);

    logic [WUW-1:0]  wu;
    logic            stg_valid;
    logic [WOUT-1:0] stg_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            warming_c;
    logic            keep_c;
    logic            pop_c;
    logic            drop_c;
    rs_t             rs_c;

    assign warming_c = (wu < WUW'(WARMUP));
    assign keep_c    = in_valid & ~warming_c & (phase == PW'(OFFSET));
    assign rs_c      = round_sat($signed(in_data));
    assign out_valid = ~fifo_empty;
    assign pop_c     = out_valid & out_ready;
    // Stage sample lost only if the FIFO is full and nothing leaves this cycle.
    assign drop_c    = stg_valid & fifo_full & ~pop_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wu        <= '0;
            phase     <= '0;
            stg_valid <= 1'b0;
            stg_data  <= '0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else if (sync_clr) begin
            wu        <= '0;
            phase     <= '0;
            stg_valid <= 1'b0;
            stg_data  <= '0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            if (in_valid) begin
                if (warming_c) wu <= wu + WUW'(1);
                else phase <= (phase == PW'(DEC - 1)) ? '0 : phase + PW'(1);
            end
            stg_valid <= keep_c;
            if (keep_c) begin
                stg_data <= rs_c.data;
                if (rs_c.sat) sat_flag <= 1'b1;
            end
            if (drop_c) drop_flag <= 1'b1;
        end
    end

    fir_dec_fifo #(
        .W (WOUT),
        .D (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (sync_clr),
        .push  (stg_valid),
        .pop   (pop_c),
        .wdata (stg_data),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fir_dec_downsampler.sv
// Self-checking bench: directed phases plus a random stream, scored against a queue-based model.
module tb_fir_dec_downsampler;

    localparam int T_WARM  = 21;
    localparam int T_DEC   = 3;
    localparam int T_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sync_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [19:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic [1:0]  phase;
    logic        sat_flag;
    logic        drop_flag;

    int n_assert = 0;
    int n_fail   = 0;

    int mq[$];
    bit pend_v;
    int pend_d;
    int n_in;
    bit e_sat;
    bit e_drop;

    fir_dec_downsampler dut (
        .clk       (clk),
        .reset     (reset),
        .sync_clr  (sync_clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .phase     (phase),
        .sat_flag  (sat_flag),
        .drop_flag (drop_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend_v = 0;
        pend_d = 0;
        n_in   = 0;
        e_sat  = 0;
        e_drop = 0;
    endtask

    // floor((x + 128) / 256), clamped to [-2048, 2047]
    function automatic int ref_round(input int x, output bit sat);
        int s;
        int r;
        s   = x + 128;
        r   = (s >= 0) ? s / 256 : -((-s + 255) / 256);
        sat = 0;
        if (r > 2047) begin r = 2047; sat = 1; end
        if (r < -2048) begin r = -2048; sat = 1; end
        return r;
    endfunction

    // Check DUT against model, advance model by one clock, then check post-edge state.
    task automatic tick();
        int sz;
        bit pop;
        bit s;
        chk("out_valid", int'(out_valid), int'(mq.size() > 0));
        if (mq.size() > 0) chk("out_data", int'($signed(out_data)), mq[0]);
        sz  = mq.size();
        pop = out_ready && (sz > 0);
        if (sync_clr) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (pend_v) begin
                if (sz < T_DEPTH || pop) mq.push_back(pend_d);
                else e_drop = 1;
            end
            pend_v = 0;
            if (in_valid) begin
                if (n_in >= T_WARM && (n_in - T_WARM) % T_DEC == 0) begin
                    pend_v = 1;
                    pend_d = ref_round(int'($signed(in_data)), s);
                    if (s) e_sat = 1;
                end
                n_in++;
            end
        end
        @(posedge clk);
        #1;
        chk("phase", int'(phase), (n_in < T_WARM) ? 0 : (n_in - T_WARM) % T_DEC);
        chk("sat_flag", int'(sat_flag), int'(e_sat));
        chk("drop_flag", int'(drop_flag), int'(e_drop));
    endtask

    task automatic feed(input int x, input bit v = 1'b1);
        in_valid = v;
        in_data  = 20'(x);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) feed(0, 1'b0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (mq.size() > 0 || pend_v); k++) idle(1);
        idle(1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_phase"}, int'(phase), 0);
        chk({tag, "_sat"}, int'(sat_flag), 0);
        chk({tag, "_drop"}, int'(drop_flag), 0);
    endtask

    initial begin
        int rnd_seq[12];
        rnd_seq = '{128, 0, 0, -129, 0, 0, 524287, 0, 0, -524288, 0, 0};
        model_reset();

        // Reset state
        #12;
        check_cleared("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Warm-up: nothing kept, phase stays 0
        out_ready = 1'b1;
        repeat (T_WARM) feed(1000);
        chk("warmup_quiet", int'(out_valid), 0);

        // Ramp: every third sample emerges as i, two clocks later
        for (int i = 0; i < 12; i++) feed(256 * i);
        idle(3);

        // Rounding and saturation corners
        for (int i = 0; i < 12; i++) feed(rnd_seq[i]);
        idle(3);
        chk("sat_set", int'(sat_flag), 1);

        // Fill FIFO, then push and pop in the same cycle while full
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) feed(int'($urandom_range(0, 200000)) - 100000);
        idle(2);
        feed(77777);
        out_ready = 1'b1;
        feed(5);
        feed(6);
        drain();
        chk("no_drop", int'(drop_flag), 0);

        // Overflow: six kept samples with stalled consumer
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) feed(int'($urandom_range(0, 400000)) - 200000);
        idle(4);
        chk("drop_set", int'(drop_flag), 1);
        drain();

        // Async reset mid-stream with two entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) feed(int'($urandom_range(0, 60000)));
        idle(2);
        chk("pre_reset_valid", int'(out_valid), 1);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_cleared("midreset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (T_WARM) feed(int'($urandom));
        for (int i = 0; i < 6; i++) feed(int'($urandom));
        drain();

        // sync_clr mid-stream, with a concurrent input that must be ignored
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) feed(int'($urandom_range(0, 60000)));
        idle(2);
        sync_clr = 1'b1;
        feed(1234);
        sync_clr = 1'b0;
        check_cleared("syncclr");
        out_ready = 1'b1;
        repeat (T_WARM) feed(int'($urandom));

        // Random stream with random gaps and backpressure
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            feed(int'($urandom), ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
